// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential RV32M multiply/divide unit.
//
// Decodes funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) and works
// on unsigned operand magnitudes. It does one shift-add or restoring-divide
// step per cycle and applies the result sign at the end. Divide-by-zero and
// signed overflow finish through a one-cycle fast path.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset
//   valid_i   request strobe, accepted when valid_i & ready_o
//   funct3_i  operation select, sampled at accept
//   a_i, b_i  operands rs1 / rs2, sampled at accept
//   ready_o   unit idle and able to accept a request
//   busy_o    operation in flight (core stall)
//   done_o    one-cycle pulse, result_o valid
//   result_o  registered result, held until the next completion
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q;       // multiplicand magnitude / dividend, then quotient
    logic [XLEN-1:0]   b_q;       // multiplier magnitude (shifted out MSB first) / divisor
    logic              neg_q;     // result must be negated at the end
    logic [2*XLEN-1:0] acc_q;     // product, or partial remainder in the low half
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   result_q;

    // Accept-time decode.
    logic            a_neg, b_neg, sign_d;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] fast_res;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        a_neg    = (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110}) & a_i[XLEN-1];
        b_neg    = (funct3_i inside {3'b000, 3'b001, 3'b100, 3'b110}) & b_i[XLEN-1];
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;
        // A remainder takes the dividend's sign; everything else takes the XOR.
        sign_d   = (funct3_i[2] & funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = funct3_i[2] & (b_i == '0);
        div_ovf  = funct3_i[2] & ~funct3_i[0] & (a_i == MIN_VAL) & (b_i == '1);
        fast_res = '0;
        if (div_zero)
            fast_res = funct3_i[1] ? a_i : '1;
        else if (div_ovf)
            fast_res = funct3_i[1] ? '0 : MIN_VAL;
    end

    // One iteration step plus the sign-corrected final result.
    logic [2*XLEN-1:0] acc_d, addend, prod;
    logic [XLEN-1:0]   a_d, b_d, quo, rem, final_res;
    logic [XLEN:0]     trial, diff;

    always_comb begin
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        addend = '0;
        // Restoring step: shift the next dividend bit into the remainder and
        // subtract the divisor. A borrow in the top bit means the subtraction
        // does not fit.
        trial  = {acc_q[XLEN-1:0], a_q[XLEN-1]};
        diff   = trial - {1'b0, b_q};
        if (op_q[2]) begin
            a_d   = {a_q[XLEN-2:0], ~diff[XLEN]};
            acc_d = {{XLEN{1'b0}}, diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0]};
        end else begin
            // MSB-first shift-add: double the product, then add the
            // multiplicand if the current multiplier bit is set.
            if (b_q[XLEN-1])
                addend = {{XLEN{1'b0}}, a_q};
            acc_d = {acc_q[2*XLEN-2:0], 1'b0} + addend;
            b_d   = {b_q[XLEN-2:0], 1'b0};
        end

        prod = neg_q ? -acc_d : acc_d;
        quo  = neg_q ? -a_d : a_d;
        rem  = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        case (op_q)
            3'b000:                 final_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo;
            default:                final_res = rem;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        op_q <= funct3_i;
                        if (div_zero || div_ovf) begin
                            result_q <= fast_res;
                            state_q  <= DONE;
                        end else begin
                            a_q     <= a_mag;
                            b_q     <= b_mag;
                            neg_q   <= sign_d;
                            acc_q   <= '0;
                            cnt_q   <= CW'(XLEN);
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    a_q   <= a_d;
                    b_q   <= b_d;
                    cnt_q <= cnt_q - CW'(1);
                    // Last step: the result is formed from this step's values.
                    if (cnt_q == CW'(1)) begin
                        result_q <= final_res;
                        state_q  <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign busy_o   = ~ready_o;
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq at XLEN=32 and XLEN=8.
// Stimulus pushes the expected result and completion cycle; per-instance
// monitors pop and compare whenever done_o is seen.
module tb_muldiv_seq;

    typedef struct {
        string       name;
        logic [31:0] exp;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        valid32 = 1'b0;
    logic [2:0]  f32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        ready32, busy32, done32;
    logic [31:0] res32;

    logic        valid8 = 1'b0;
    logic [2:0]  f8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ready8, busy8, done8;
    logic [7:0]  res8;

    exp_t sb32[$];
    exp_t sb8[$];
    exp_t m32, m8;

    muldiv_seq #(.XLEN(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid32), .funct3_i(f32),
        .a_i(a32), .b_i(b32), .ready_o(ready32), .busy_o(busy32),
        .done_o(done32), .result_o(res32)
    );

    muldiv_seq #(.XLEN(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid8), .funct3_i(f8),
        .a_i(a8), .b_i(b8), .ready_o(ready8), .busy_o(busy8),
        .done_o(done8), .result_o(res8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitors: every done pulse must match the head of its scoreboard.
    always @(negedge clk) begin
        if (done32 === 1'b1) begin
            if (sb32.size() == 0) fail_now("done32 with nothing outstanding");
            else begin
                m32 = sb32.pop_front();
                check({m32.name, " result"}, res32, m32.exp);
                check({m32.name, " done cycle"}, 32'(cyc), 32'(m32.cyc));
            end
        end
        if (done8 === 1'b1) begin
            if (sb8.size() == 0) fail_now("done8 with nothing outstanding");
            else begin
                m8 = sb8.pop_front();
                check({m8.name, " result"}, {24'h0, res8}, m8.exp);
                check({m8.name, " done cycle"}, 32'(cyc), 32'(m8.cyc));
            end
        end
    end

    task automatic wait_ready32();
        int t = 0;
        while (ready32 !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (ready32 !== 1'b1) fail_now("ready32 wait timeout");
    endtask

    task automatic wait_ready8();
        int t = 0;
        while (ready8 !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (ready8 !== 1'b1) fail_now("ready8 wait timeout");
    endtask

    // Issue one XLEN=32 op in the current cycle n; expect done at n+lat.
    // With hold set, valid stays high with junk operands for the whole run.
    task automatic issue(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input bit hold, output int n);
        exp_t e;
        bit   busy_ok;
        wait_ready32();
        n       = cyc;
        valid32 = 1'b1;
        f32     = f;
        a32     = a;
        b32     = b;
        e.name  = name;
        e.exp   = exp;
        e.cyc   = n + lat;
        sb32.push_back(e);
        busy_ok = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (hold) begin
                f32 = 3'($urandom);
                a32 = $urandom;
                b32 = $urandom;
            end else begin
                valid32 = 1'b0;
            end
            if (busy32 !== 1'b1 || ready32 !== 1'b0) busy_ok = 1'b0;
        end
        check({name, " busy during op"}, {31'h0, busy_ok}, 32'h1);
        @(negedge clk);
        check({name, " ready after done"}, {31'h0, ready32}, 32'h1);
    endtask

    task automatic issue8(input string name, input logic [2:0] f, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp);
        exp_t e;
        wait_ready8();
        valid8 = 1'b1;
        f8     = f;
        a8     = a;
        b8     = b;
        e.name = name;
        e.exp  = {24'h0, exp};
        e.cyc  = cyc + 9;
        sb8.push_back(e);
        @(negedge clk);
        valid8 = 1'b0;
    endtask

    initial begin
        int n, n2, t;

        // Reset state, observed while reset is still asserted.
        repeat (3) @(negedge clk);
        check("reset ready", {31'h0, ready32}, 32'h1);
        check("reset busy", {31'h0, busy32}, 32'h0);
        check("reset done", {31'h0, done32}, 32'h0);
        check("reset result", res32, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Multiplies.
        issue("MUL",    3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0, n);
        issue("MULH",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0, n);
        issue("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0, n);
        issue("MULHSU", 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33, 1'b0, n);

        // Divides.
        issue("DIV",  3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, 1'b0, n);
        issue("REM",  3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, 1'b0, n);
        issue("DIVU", 3'b101, 32'd100,      32'd7,        32'd14,       33, 1'b0, n);
        issue("REMU", 3'b111, 32'd100,      32'd7,        32'd2,        33, 1'b0, n);

        // Fast path: divide by zero and signed overflow.
        issue("DIVU by 0",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 1'b0, n);
        issue("DIV neg by 0", 3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1, 1'b0, n);
        issue("REM by 0",     3'b110, 32'd5,        32'd0,        32'd5,        1, 1'b0, n);
        issue("DIV overflow", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0, n);
        issue("REM overflow", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1'b0, n);

        // Handshake: valid held with changing operands, then back-to-back.
        issue("MUL held valid", 3'b000, 32'h00012345, 32'h00000100, 32'h01234500, 33, 1'b1, n);
        issue("DIVU back-to-back", 3'b101, 32'd1000, 32'd10, 32'd100, 33, 1'b0, n2);
        check("second accept cycle", 32'(n2), 32'(n + 34));

        // Reset in the middle of a multiply aborts it.
        wait_ready32();
        n       = cyc;
        valid32 = 1'b1;
        f32     = 3'b000;
        a32     = 32'd9;
        b32     = 32'd9;
        @(negedge clk);
        valid32 = 1'b0;
        while (cyc < n + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-op reset ready", {31'h0, ready32}, 32'h1);
        check("mid-op reset result", res32, 32'h0);
        check("mid-op reset done", {31'h0, done32}, 32'h0);
        repeat (40) @(negedge clk);
        issue("MUL after reset", 3'b000, 32'd123, 32'd456, 32'h0000DB18, 33, 1'b0, n);

        // Reset coincident with a request: the request is dropped.
        wait_ready32();
        valid32 = 1'b1;
        f32     = 3'b101;
        a32     = 32'd5;
        b32     = 32'd0;
        rst     = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        valid32 = 1'b0;
        check("reset+valid ready", {31'h0, ready32}, 32'h1);
        check("reset+valid busy", {31'h0, busy32}, 32'h0);
        repeat (5) @(negedge clk);
        check("reset+valid result", res32, 32'h0);

        // XLEN=8 instance.
        issue8("MULH8", 3'b001, 8'h80, 8'h7F, 8'hC0);
        issue8("DIV8",  3'b100, 8'h81, 8'h03, 8'hD6);

        // Drain both scoreboards with a bound.
        t = 0;
        while ((sb32.size() != 0 || sb8.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb32.size() != 0) fail_now("XLEN=32 results never completed");
        if (sb8.size() != 0) fail_now("XLEN=8 results never completed");
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
